// File: rtl/vga_pkg.sv
// vga_pkg: shared frame-buffer dimensions, helper functions and FSM state type
// for the paletted double-buffered VGA frame buffer.
package vga_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic {
    IDLE,
    CLEAR
  } fb_state_t;

  function automatic int fb_dim(input int res, input int sh);
    return res >> sh;
  endfunction

  function automatic int fb_bits(input int res, input int sh);
    return $clog2(res >> sh);
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// fb_dpram: simple dual-port pixel RAM, one write port and one registered
// read port (read-before-write on address collision).
module fb_dpram #(
  parameter int    AW        = 10,
  parameter int    DW        = 8,
  parameter string INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/vga_fb.sv
// vga_fb: paletted double-buffered frame buffer with writer port, clear
// engine and frame-synchronous page swap, scanned out in a 2-stage pipeline.
module vga_fb
  import vga_pkg::*;
#(
  parameter int    H_RES     = H_RES_DEF,
  parameter int    V_RES     = V_RES_DEF,
  parameter int    SCALE_SH  = 1,
  parameter int    CW        = 8,
  parameter string INIT_FILE = "",
  localparam int   FB_W      = fb_dim(H_RES, SCALE_SH),
  localparam int   FB_H      = fb_dim(V_RES, SCALE_SH),
  localparam int   XW        = fb_bits(H_RES, SCALE_SH),
  localparam int   YW        = fb_bits(V_RES, SCALE_SH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  input  logic          frame_start,
  output logic [23:0]   vga_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [CW-1:0] wr_color,
  output logic          wr_oob,
  input  logic          clr_req,
  input  logic [CW-1:0] clr_color,
  output logic          clr_busy,
  input  logic          swap_req,
  output logic          swap_pend,
  output logic          front_page,
  input  logic          pal_we,
  input  logic [CW-1:0] pal_idx,
  input  logic [23:0]   pal_rgb
);

  localparam int         AW    = 1 + XW + YW;
  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);
  localparam logic [XW:0] X_LIM = (XW+1)'(FB_W);
  localparam logic [YW:0] Y_LIM = (YW+1)'(FB_H);

  fb_state_t        state_q, state_d;
  logic [AW-2:0]    cnt_q, cnt_d;
  logic [CW-1:0]    clr_col_q, clr_col_d;
  logic             front_q, front_d;
  logic             pend_q, pend_d;
  logic             oob_q, oob_d;
  logic             wr_in_rng, do_swap;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [CW-1:0]    ram_wdata, ram_rdata;

  logic [XW-1:0]    sx_q;
  logic [YW-1:0]    sy_q;
  logic             s1_vld_q, s2_vld_q;
  logic [23:0]      vga_q;
  logic [23:0]      pal_q [2**CW];

  assign wr_in_rng = ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
  assign do_swap   = frame_start && pend_q && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_col_d = clr_col_q;
    wr_ready  = 1'b0;
    clr_busy  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    unique case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_in_rng) begin
          ram_we    = 1'b1;
          ram_waddr = {~front_q, wr_y, wr_x};
          ram_wdata = wr_color;
        end
        if (clr_req) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          clr_col_d = clr_color;
        end
      end
      CLEAR: begin
        clr_busy  = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = {~front_q, cnt_q};
        ram_wdata = clr_col_q;
        cnt_d     = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    oob_d   = wr_valid && wr_ready && !wr_in_rng;
    front_d = front_q ^ do_swap;
    pend_d  = do_swap ? 1'b0 : (pend_q | swap_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clr_col_q <= '0;
      front_q   <= 1'b0;
      pend_q    <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_col_q <= clr_col_d;
      front_q   <= front_d;
      pend_q    <= pend_d;
      oob_q     <= oob_d;
    end
  end

  // Grey-ramp default palette; a same-cycle write is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**CW; i++)
        pal_q[i] <= {3{8'(i << (8 - CW))}};
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_rgb;
    end
  end

  assign ram_raddr = {front_q, sy_q, sx_q};

  fb_dpram #(
    .AW        (AW),
    .DW        (CW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_q     <= '0;
      sy_q     <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      vga_q    <= '0;
    end else begin
      sx_q     <= h_addr[SCALE_SH +: XW];
      sy_q     <= v_addr[SCALE_SH +: YW];
      s1_vld_q <= (h_addr < H_LIM) && (v_addr < V_LIM);
      s2_vld_q <= s1_vld_q;
      vga_q    <= s2_vld_q ? pal_q[ram_rdata] : '0;
    end
  end

  assign vga_data   = vga_q;
  assign wr_oob     = oob_q;
  assign swap_pend  = pend_q;
  assign front_page = front_q;

endmodule

// File: tb/tb_vga_fb.sv
// tb_vga_fb: directed plus randomized bench for vga_fb, scored every cycle
// against an array-based reference of pages, palette and swap/clear rules.
module tb_vga_fb;

  localparam int HR = 80;
  localparam int VR = 60;
  localparam int FW = 40;
  localparam int FH = 30;
  localparam int XN = 64;
  localparam int YN = 32;
  localparam int PG = XN * YN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_addr = '0;
  logic [9:0]  v_addr = '0;
  logic        frame_start = 1'b0;
  logic [23:0] vga_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_x = '0;
  logic [4:0]  wr_y = '0;
  logic [7:0]  wr_color = '0;
  logic        wr_oob;
  logic        clr_req = 1'b0;
  logic [7:0]  clr_color = '0;
  logic        clr_busy;
  logic        swap_req = 1'b0;
  logic        swap_pend;
  logic        front_page;
  logic        pal_we = 1'b0;
  logic [7:0]  pal_idx = '0;
  logic [23:0] pal_rgb = '0;

  int n_chk = 0;
  int n_err = 0;

  vga_fb #(
    .H_RES     (HR),
    .V_RES     (VR),
    .SCALE_SH  (1),
    .CW        (8),
    .INIT_FILE ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .h_addr      (h_addr),
    .v_addr      (v_addr),
    .frame_start (frame_start),
    .vga_data    (vga_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .wr_oob      (wr_oob),
    .clr_req     (clr_req),
    .clr_color   (clr_color),
    .clr_busy    (clr_busy),
    .swap_req    (swap_req),
    .swap_pend   (swap_pend),
    .front_page  (front_page),
    .pal_we      (pal_we),
    .pal_idx     (pal_idx),
    .pal_rgb     (pal_rgb)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [7:0]  ram_m [2*PG];
  bit          known [2*PG];
  logic [23:0] pal_m [256];
  bit          m_fp, m_pend, m_busy, m_oob;
  int          m_cnt;
  logic [7:0]  m_col;
  int          m_x1, m_y1;
  bit          m_f1, m_f2, m_k2, m_vk;
  logic [7:0]  m_idx2;
  logic [23:0] m_vga;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int adr(input bit p, input int y, input int x);
    return int'(p) * PG + y * XN + x;
  endfunction

  function automatic void fill_page(input bit p, input logic [7:0] c);
    for (int y = 0; y < YN; y++)
      for (int x = 0; x < XN; x++) begin
        ram_m[adr(p, y, x)] = c;
        known[adr(p, y, x)] = 1'b1;
      end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) pal_m[i] = {3{8'(i)}};
    m_fp = 0; m_pend = 0; m_busy = 0; m_oob = 0; m_cnt = 0;
    m_col = '0; m_x1 = 0; m_y1 = 0;
    m_f1 = 0; m_f2 = 0; m_k2 = 0; m_vk = 1; m_idx2 = '0;
    m_vga = '0;
  endfunction

  task automatic idle_inputs();
    wr_valid = 0; clr_req = 0; swap_req = 0;
    frame_start = 0; pal_we = 0;
  endtask

  // One clock: predict from pre-edge inputs/state, then compare after edge.
  task automatic cyc();
    bit acc, inr, swp, vk_n, k2_n, f2_n, f1_n, oob_n;
    logic [23:0] vga_n;
    logic [7:0] idx2_n;
    int a, x1_n, y1_n;
    acc    = wr_valid && !m_busy;
    inr    = (int'(wr_x) < FW) && (int'(wr_y) < FH);
    oob_n  = acc && !inr;
    vga_n  = m_f2 ? pal_m[m_idx2] : 24'h0;
    vk_n   = !m_f2 || m_k2;
    a      = adr(m_fp, m_y1, m_x1);
    idx2_n = ram_m[a];
    k2_n   = known[a];
    f2_n   = m_f1;
    x1_n   = (int'(h_addr) / 2) % XN;
    y1_n   = (int'(v_addr) / 2) % YN;
    f1_n   = (int'(h_addr) < HR) && (int'(v_addr) < VR);
    swp    = frame_start && m_pend && !m_busy;
    if (acc && inr) begin
      ram_m[adr(!m_fp, int'(wr_y), int'(wr_x))] = wr_color;
      known[adr(!m_fp, int'(wr_y), int'(wr_x))] = 1'b1;
    end
    if (pal_we) pal_m[pal_idx] = pal_rgb;
    if (m_busy) begin
      m_cnt++;
      if (m_cnt == PG) begin
        m_busy = 0;
        fill_page(!m_fp, m_col);
      end
    end else if (clr_req) begin
      m_busy = 1; m_cnt = 0; m_col = clr_color;
    end
    if (swp) begin
      m_fp = !m_fp; m_pend = 0;
    end else if (swap_req) begin
      m_pend = 1;
    end
    m_vga = vga_n; m_vk = vk_n;
    m_idx2 = idx2_n; m_k2 = k2_n; m_f2 = f2_n;
    m_x1 = x1_n; m_y1 = y1_n; m_f1 = f1_n;
    m_oob = oob_n;
    @(posedge clk);
    #1;
    if (m_vk) check("vga", vga_data, m_vga);
    check("wr_ready", wr_ready, !m_busy);
    check("clr_busy", clr_busy, m_busy);
    check("swap_pend", swap_pend, m_pend);
    check("front_page", front_page, m_fp);
    check("wr_oob", wr_oob, m_oob);
  endtask

  task automatic scan(input int h, input int v);
    h_addr = 10'(h); v_addr = 10'(v);
    repeat (3) cyc();
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (clr_busy && n < 3000) begin
      n++;
      cyc();
    end
    check(tag, clr_busy, 1'b0);
  endtask

  task automatic do_swap();
    swap_req = 1; cyc(); swap_req = 0;
    frame_start = 1; cyc(); frame_start = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2*PG; i++) begin
      known[i] = 1'b0;
      ram_m[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_vga", vga_data, 24'h0);
    check("rst_ready", wr_ready, 1'b1);
    check("rst_oob", wr_oob, 1'b0);
    check("rst_busy", clr_busy, 1'b0);
    check("rst_pend", swap_pend, 1'b0);
    check("rst_front", front_page, 1'b0);
    rst = 0;

    // Pixel (3,2)=0x80 into page 1, swap, scan with default grey palette
    wr_valid = 1; wr_x = 3; wr_y = 2; wr_color = 8'h80;
    cyc();
    wr_valid = 0;
    do_swap();
    check("t1_front", front_page, 1'b1);
    scan(6, 4);
    check("t1_pix", vga_data, 24'h808080);
    scan(HR, 4);
    check("t2_h_edge", vga_data, 24'h0);
    scan(6, VR);
    check("t2_v_edge", vga_data, 24'h0);
    scan(7, 5);
    check("t2_mirror", vga_data, 24'h808080);

    // Clear back page 0, count busy cycles, then inspect every word
    clr_req = 1; clr_color = 8'h11; cyc(); clr_req = 0;
    n = 0;
    while (clr_busy && n < 3000) begin
      n++;
      check("t3_ready_low", wr_ready, 1'b0);
      cyc();
    end
    check("t3_len", n, PG);
    do_swap();
    check("t3_front", front_page, 1'b0);
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) begin
        h_addr = 10'(2 * x); v_addr = 10'(2 * y);
        cyc();
      end
    scan(2 * (FW - 1), 2 * (FH - 1));
    check("t3_word", vga_data, 24'h111111);

    // Swap requested during a clear waits for clear completion
    clr_req = 1; clr_color = 8'h22; cyc(); clr_req = 0;
    swap_req = 1; cyc(); swap_req = 0;
    repeat (100) cyc();
    frame_start = 1; cyc(); frame_start = 0;
    check("t4_hold", front_page, 1'b0);
    check("t4_pend", swap_pend, 1'b1);
    wait_clear("t4_clr_done");
    repeat (5) cyc();
    check("t4_still", front_page, 1'b0);
    frame_start = 1; cyc(); frame_start = 0;
    check("t4_toggle", front_page, 1'b1);

    // Out-of-range write and same-cycle palette update
    wr_valid = 1; wr_x = 6'(FW); wr_y = 0; wr_color = 8'h55;
    cyc();
    wr_valid = 0;
    check("t5_oob", wr_oob, 1'b1);
    cyc();
    check("t5_oob_once", wr_oob, 1'b0);
    wr_valid = 1; wr_x = 0; wr_y = 0; wr_color = 8'h80;
    cyc();
    wr_valid = 0;
    do_swap();
    scan(0, 0);
    check("t5_pix", vga_data, 24'h808080);
    pal_we = 1; pal_idx = 8'h80; pal_rgb = 24'hFF0000;
    cyc();
    pal_we = 0;
    check("t5_pal_old", vga_data, 24'h808080);
    cyc();
    check("t5_pal_new", vga_data, 24'hFF0000);

    // Randomized traffic scored by the reference
    for (int i = 0; i < 4000; i++) begin
      wr_valid    = 1'($urandom_range(0, 1));
      wr_x        = 6'($urandom_range(0, 63));
      wr_y        = 5'($urandom_range(0, 31));
      wr_color    = 8'($urandom);
      pal_we      = ($urandom_range(0, 19) == 0);
      pal_idx     = 8'($urandom);
      pal_rgb     = 24'($urandom);
      swap_req    = ($urandom_range(0, 49) == 0);
      frame_start = ($urandom_range(0, 99) == 0);
      clr_req     = ($urandom_range(0, 1999) == 0);
      clr_color   = 8'($urandom);
      h_addr      = 10'($urandom_range(0, 95));
      v_addr      = 10'($urandom_range(0, 71));
      cyc();
    end
    idle_inputs();
    wait_clear("rand_clr_done");

    // Reset in the middle of a clear with a swap pending
    clr_req = 1; clr_color = 8'h05; cyc(); clr_req = 0;
    swap_req = 1; cyc(); swap_req = 0;
    repeat (10) cyc();
    #2;
    rst = 1;
    #1;
    check("t6_vga", vga_data, 24'h0);
    check("t6_ready", wr_ready, 1'b1);
    check("t6_oob", wr_oob, 1'b0);
    check("t6_busy", clr_busy, 1'b0);
    check("t6_pend", swap_pend, 1'b0);
    check("t6_front", front_page, 1'b0);
    for (int i = 0; i < PG; i++) known[adr(!m_fp, 0, 0) + i] = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    h_addr = 10'd6; v_addr = 10'd4;
    repeat (20) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
